mem_dp_rd_streamer: RTL
=======================

Name: mem_dp_rd_streamer

Overview:
- Read-side companion of the 512x32 dual-port block-RAM wrapper. It drives one RAM port (clk/en/wen/adr in, rdata out) and turns a (start address, length) command into a word stream with valid/ready flow control.
- The RAM port has 1-cycle read latency, and its output holds until the next enable. A 2-entry output buffer plus credit-based issue gives full throughput under backpressure.
- Used by DMA/packet-egress logic to drain buffers held in the dual-port memory.

Parameters:
ADR_W, 9, RAM word-address width (512 words)
DATA_W, 32, RAM word width
LEN_W, 10, command length width (holds 0..512)

Ports:
clk  in  1  clock; also drives the RAM port clock
rst  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_adr  in  ADR_W  first word address
i_cmd_len  in  LEN_W  word count, 0..512
o_mem_en  out  1  RAM port enable (read issue)
o_mem_wen  out  4  RAM byte write enables, tied 4'b0
o_mem_adr  out  ADR_W  RAM read address
i_mem_rdata  in  DATA_W  RAM read data, valid the cycle after o_mem_en
o_data_valid  out  1  output word valid
i_data_ready  in  1  consumer accepts the word
o_data  out  DATA_W  output word (buffer head)
o_data_last  out  1  marks the final word of a command
o_done  out  1  one-cycle pulse when the command completes

Behaviour:
- Reset (sync, active-high): state IDLE; o_cmd_ready=1; o_mem_en=0; o_data_valid=0; o_data=0; o_data_last=0; o_done=0; buffer emptied; in-flight flag cleared. Reset mid-command aborts it: no o_done, and any pending RAM data is ignored.
- States:
  - IDLE: o_cmd_ready=1. On accept, latch adr, remaining=len and words_out=len.
    - len=0: go to DONE.
    - len>512 (illegal): saturate to 512.
    - otherwise: go to RUN.
  - RUN: o_cmd_ready=0. Issue reads until remaining=0, then go to DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight, then go to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE. A command can be accepted the cycle after DONE.
- Issue rule (combinational o_mem_en in RUN): remaining>0 and (occ + inflight - pop) < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: a read was issued last cycle.
  - pop: o_data_valid & i_data_ready.
- On issue: o_mem_adr=adr; adr increments mod 512 (511 wraps to 0); remaining decrements.
- Capture: in the cycle after an issue, i_mem_rdata is written into the buffer tail. The issue rule guarantees no overflow.
- Buffer: 2-entry FIFO. o_data_valid=(occ>0). o_data and o_data_last show the head entry. Simultaneous push and pop at occ=1 or occ=2 is legal, and occupancy is unchanged.
- o_data_last is set on the entry whose issue made remaining 1→0.
- Latency and throughput:
  - Accept at cycle 0.
  - First o_mem_en in cycle 1.
  - First o_data_valid in cycle 3.
  - With i_data_ready held high, one word per cycle.
  - o_done in the cycle after the last-word handshake.
- Backpressure: with i_data_ready low, at most 2 words are buffered. Issue stalls and RAM addresses are not skipped; the word order is strictly increasing (mod 512).
- o_data and o_data_last are don't-care when o_data_valid=0. Registers hold their values.
- o_mem_wen is constant 0. This block never writes the RAM.

Decomposition:
- Shared header/package: MEM_ADR_W=9, MEM_DATA_W=32, MEM_WEN_W=4, MEM_DEPTH=512, and state encodings ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE.
- One sub-module: rd_fifo2, a 2-entry FIFO of {last, data} with push/pop/occ outputs, synchronous reset.
- The issue/credit logic and the FSM stay in the top level.

Test Plan:
- adr=0x010, len=4, ready=1 → mem_en cycles 1-4 with adr 0x010-0x013; data valid cycles 3-6 with RAM contents in order; last on the 4th word; o_done cycle 7.
- adr=0x1FE, len=4 → RAM reads 0x1FE, 0x1FF, 0x000, 0x001; 4 words out, last on 0x001's data.
- len=8, ready toggled 1,0,0,1 repeating → never more than 2 words buffered; no lost or duplicated words; 8 handshakes, then o_done.
- len=0 → accepted, o_done the next cycle, no mem_en, no data_valid.
- len=512, ready=1 → 512 consecutive words at 1/cycle after the 2-cycle fill; o_done; then a back-to-back second command is accepted the cycle after o_done.
- rst asserted in RUN with 1 read in flight and 2 words buffered → next cycle all outputs at reset values; a new len=2 command completes correctly with no stale data.

Source files
------------

// File: rtl/mem_dp_rd_streamer_pkg.sv
// Shared constants and FSM encoding for the dual-port RAM read streamer.
package mem_dp_rd_streamer_pkg;

  localparam int unsigned MEM_ADR_W  = 9;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_WEN_W  = 4;
  localparam int unsigned MEM_DEPTH  = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_dp_rd_streamer_rd_fifo2.sv
// Two-entry FIFO holding {last, data} words captured from the RAM read port.
module mem_dp_rd_streamer_rd_fifo2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        occ
);

  logic [DATA_W:0] mem_q [2];
  logic            rd_ptr_q;
  logic            wr_ptr_q;
  logic [1:0]      occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {push_last, push_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push && !pop) begin
        occ_q <= occ_q + 2'd1;
      end else if (!push && pop) begin
        occ_q <= occ_q - 2'd1;
      end
    end
  end

  assign {head_last, head_data} = mem_q[rd_ptr_q];
  assign occ = occ_q;

endmodule

// File: rtl/mem_dp_rd_streamer.sv
// Streams a (start address, length) range out of one dual-port RAM port with
// valid/ready flow control, using credit-based issue into a 2-entry buffer.
module mem_dp_rd_streamer
  import mem_dp_rd_streamer_pkg::*;
#(
  parameter int unsigned ADR_W  = MEM_ADR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned LEN_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [ADR_W-1:0]     i_cmd_adr,
  input  logic [LEN_W-1:0]     i_cmd_len,
  output logic                 o_mem_en,
  output logic [MEM_WEN_W-1:0] o_mem_wen,
  output logic [ADR_W-1:0]     o_mem_adr,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_data_last,
  output logic                 o_done
);

  state_e           state_q;
  logic [ADR_W-1:0] adr_q;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] words_out_q;
  logic             inflight_q;
  logic             last_inflight_q;
  logic             cmd_ready_q;
  logic             done_q;

  logic [1:0]       occ;
  logic             pop;
  logic             issue;
  logic [2:0]       credit_used;
  logic [LEN_W-1:0] len_sat;

  assign pop = o_data_valid & i_data_ready;

  // Slots committed after this cycle: buffered plus in flight, minus the word leaving now.
  assign credit_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == ST_RUN) && (remaining_q != '0) && (credit_used < 3'd2);

  assign len_sat = (i_cmd_len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : i_cmd_len;

  assign o_mem_en    = issue;
  assign o_mem_adr   = adr_q;
  assign o_mem_wen   = '0;
  assign o_cmd_ready = cmd_ready_q;
  assign o_done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      adr_q           <= '0;
      remaining_q     <= '0;
      words_out_q     <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      cmd_ready_q     <= 1'b1;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      last_inflight_q <= issue && (remaining_q == LEN_W'(1));
      done_q          <= 1'b0;
      if (issue) begin
        adr_q       <= adr_q + ADR_W'(1);
        remaining_q <= remaining_q - LEN_W'(1);
      end
      if (pop) begin
        words_out_q <= words_out_q - LEN_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            adr_q       <= i_cmd_adr;
            remaining_q <= len_sat;
            words_out_q <= len_sat;
            cmd_ready_q <= 1'b0;
            if (len_sat == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue && (remaining_q == LEN_W'(1))) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Every word handed out implies the buffer is empty and nothing is in flight.
          if (words_out_q == LEN_W'(pop)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_dp_rd_streamer_rd_fifo2 #(
    .DATA_W(DATA_W)
  ) u_rd_fifo2 (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(i_mem_rdata),
    .push_last(last_inflight_q),
    .pop      (pop),
    .head_data(o_data),
    .head_last(o_data_last),
    .occ      (occ)
  );

  assign o_data_valid = (occ != 2'd0);

endmodule
